// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
//   Two-port arbiter in front of a single BurstRAM. Port 0 serves the
//   instruction cache, port 1 the data cache. One burst is in flight at a
//   time; simultaneous requests alternate between ports.
//
// Ports
//   clk, rst                   single clock, synchronous active-high reset
//   pN_req/cmd/addr            level request held until pN_gnt (cmd 1 = write)
//   pN_wr_data/data_mask       write beat data and byte mask
//   pN_gnt                     one-cycle pulse when the burst is issued
//   pN_rd_data                 RAM read data, broadcast to both ports
//   pN_rd_data_valid           read beat valid, routed to the burst owner only
//   pN_busy                    arbiter mid-burst or RAM busy
//   br_*                       BurstRAM command / data interface
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no burst in flight; issue to the winner when RAM is not busy
// READ   | counting owner's read beats until the last one arrives
// WRITE  | minimum hold after issue, then wait for RAM to go idle
module burst_ram_arbiter #(
  parameter int RAM_DEPTH_BITWIDTH      = 8,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_req,
  input  logic                                 p0_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p0_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p0_data_mask,
  output logic                                 p0_gnt,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_rd_data,
  output logic                                 p0_rd_data_valid,
  output logic                                 p0_busy,
  input  logic                                 p1_req,
  input  logic                                 p1_cmd,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p1_data_mask,
  output logic                                 p1_gnt,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_rd_data,
  output logic                                 p1_rd_data_valid,
  output logic                                 p1_busy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int CNT_W = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Cycles a write stays in WRITE before br_busy is allowed to release it.
  localparam logic [1:0] WR_HOLD = 2'd2;

  logic [1:0]                    state;
  logic                          owner;
  logic                          last_owner;
  logic [CNT_W-1:0]              beat_cnt;
  logic [1:0]                    wr_wait;

  logic                          issue;
  logic                          winner;
  logic                          win_cmd;
  logic [RAM_DEPTH_BITWIDTH-1:0] win_addr;

  always_comb begin
    issue    = (state == ST_IDLE) && !br_busy && (p0_req || p1_req);
    // On a tie the port that did not own the previous burst wins.
    winner   = (p0_req && p1_req) ? ~last_owner : p1_req;
    win_cmd  = winner ? p1_cmd  : p0_cmd;
    win_addr = winner ? p1_addr : p0_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
      wr_wait    <= '0;
      br_cmd     <= 1'b0;
      br_cmd_en  <= 1'b0;
      br_addr    <= '0;
      p0_gnt     <= 1'b0;
      p1_gnt     <= 1'b0;
    end else begin
      br_cmd_en <= 1'b0;
      p0_gnt    <= 1'b0;
      p1_gnt    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            br_cmd     <= win_cmd;
            br_addr    <= win_addr;
            br_cmd_en  <= 1'b1;
            p0_gnt     <= ~winner;
            p1_gnt     <= winner;
            owner      <= winner;
            last_owner <= winner;
            beat_cnt   <= '0;
            wr_wait    <= WR_HOLD;
            state      <= win_cmd ? ST_WRITE : ST_READ;
          end
        end
        ST_READ: begin
          if (br_rd_data_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (wr_wait != 2'd0) begin
            wr_wait <= wr_wait - 2'd1;
          end else if (!br_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write data follows the owner during WRITE and the winner on the cycle
  // the decision is made, so the RAM sees it alongside the command.
  always_comb begin
    br_wr_data   = '0;
    br_data_mask = '0;
    if (state == ST_WRITE) begin
      br_wr_data   = owner ? p1_wr_data   : p0_wr_data;
      br_data_mask = owner ? p1_data_mask : p0_data_mask;
    end else if (issue) begin
      br_wr_data   = winner ? p1_wr_data   : p0_wr_data;
      br_data_mask = winner ? p1_data_mask : p0_data_mask;
    end
  end

  always_comb begin
    p0_rd_data       = br_rd_data;
    p1_rd_data       = br_rd_data;
    p0_rd_data_valid = br_rd_data_valid && (state == ST_READ) && !owner;
    p1_rd_data_valid = br_rd_data_valid && (state == ST_READ) &&  owner;
    p0_busy          = (state != ST_IDLE) || br_busy;
    p1_busy          = (state != ST_IDLE) || br_busy;
  end

endmodule
